uart_colour_rx: RTL

- UART receiver and frame parser feeding the addressable-LED driver stage. Serial colour commands from the host are turned into a 24-bit colour word plus a one-cycle start strobe.
- Sits directly upstream of the WS2812 driver. It replaces the timer-derived colour path: o_Colour feeds the driver's colour input, o_Start feeds its start input, and i_LedReady comes from the driver's ready output.

---
 rtl/uart_colour_rx.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_colour_rx.sv
// uart_colour_rx
//   UART receiver (8N1, LSB first) plus frame parser for the LED colour path.
//   A frame is SYNC_BYTE, R, G, B (and a checksum byte CK when the build macro
//   UART_COLOUR_CHECKSUM_EN is defined; CK = SYNC_BYTE ^ R ^ G ^ B). A finished
//   frame is held as pending until the driver is ready, then presented on
//   o_Colour as {G,R,B} together with a one-cycle o_Start strobe.
//
// Ports
//   Clock       system clock
//   Reset       asynchronous reset, active-high
//   i_Rx        UART serial input, asynchronous to Clock
//   i_LedReady  downstream driver ready (level)
//   o_Colour    colour word {G,R,B}, changes only with o_Start
//   o_Start     one-cycle strobe, o_Colour valid
//   o_Pending   a complete frame is waiting for i_LedReady
//   o_FrameErr  one-cycle pulse: bad stop bit, inter-byte timeout, bad checksum
//   o_Overrun   one-cycle pulse: pending colour replaced before it was sent
module uart_colour_rx #(
  parameter int         CLKS_PER_BIT = 417,
  parameter int         TIMEOUT_BITS = 20,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        i_Rx,
  input  logic        i_LedReady,
  output logic [23:0] o_Colour,
  output logic        o_Start,
  output logic        o_Pending,
  output logic        o_FrameErr,
  output logic        o_Overrun
);

  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW       = $clog2(TO_LIMIT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_END  = TW'(TO_LIMIT);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
  typedef enum logic [2:0] {F_WAIT_SYNC, F_GET_R, F_GET_G, F_GET_B
`ifdef UART_COLOUR_CHECKSUM_EN
    , F_GET_CK
`endif
  } frame_state_t;

  // Synchroniser plus one history flop for falling-edge detection; all
  // reset to 1 so a reset never looks like a start bit.
  logic r_rx_meta, r_rx_s, r_rx_prev;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= i_Rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  // ---------------- bit FSM ----------------
  bit_state_t      r_bit_state;
  logic [CW-1:0]   r_clk_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_byte_valid;
  logic            r_stop_err;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_bit_state  <= B_IDLE;
      r_clk_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_stop_err   <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_stop_err   <= 1'b0;
      case (r_bit_state)
        B_IDLE: begin
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
          if (r_rx_prev && !r_rx_s) r_bit_state <= B_START;
        end
        B_START: begin
          if (r_clk_cnt == HALF_M1) begin
            r_clk_cnt   <= '0;
            // Line back high at mid start bit: a glitch, drop it quietly.
            r_bit_state <= r_rx_s ? B_IDLE : B_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        B_DATA: begin
          if (r_clk_cnt == FULL_M1) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rx_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_bit_state <= B_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        B_STOP: begin
          if (r_clk_cnt == FULL_M1) begin
            r_clk_cnt   <= '0;
            r_bit_state <= B_IDLE;
            if (r_rx_s) r_byte_valid <= 1'b1;
            else        r_stop_err   <= 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        default: r_bit_state <= B_IDLE;
      endcase
    end
  end

  // ---------------- frame FSM and output handshake ----------------
  frame_state_t  r_frame_state;
  logic [7:0]    r_sh_r, r_sh_g;
`ifdef UART_COLOUR_CHECKSUM_EN
  logic [7:0]    r_sh_b;
`endif
  logic [23:0]   r_pend;
  logic [TW-1:0] r_idle_cnt;

  logic        w_in_frame, w_timeout, w_complete, w_ck_bad, w_consume, w_abort;
  logic [23:0] w_new_colour;

  always_comb begin
    w_in_frame = (r_frame_state != F_WAIT_SYNC);
    w_timeout  = w_in_frame && (r_idle_cnt == TO_END);
    w_consume  = o_Pending && i_LedReady;
`ifdef UART_COLOUR_CHECKSUM_EN
    w_new_colour = {r_sh_g, r_sh_r, r_sh_b};
    w_complete   = r_byte_valid && !w_timeout && (r_frame_state == F_GET_CK) &&
                   (r_shift == (SYNC_BYTE ^ r_sh_r ^ r_sh_g ^ r_sh_b));
    w_ck_bad     = r_byte_valid && (r_frame_state == F_GET_CK) &&
                   (r_shift != (SYNC_BYTE ^ r_sh_r ^ r_sh_g ^ r_sh_b));
`else
    w_new_colour = {r_sh_g, r_sh_r, r_shift};
    w_complete   = r_byte_valid && !w_timeout && (r_frame_state == F_GET_B);
    w_ck_bad     = 1'b0;
`endif
    w_abort = r_stop_err || w_timeout || w_ck_bad;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_frame_state <= F_WAIT_SYNC;
      r_sh_r        <= '0;
      r_sh_g        <= '0;
`ifdef UART_COLOUR_CHECKSUM_EN
      r_sh_b        <= '0;
`endif
      r_pend        <= '0;
      r_idle_cnt    <= '0;
      o_Colour      <= '0;
      o_Start       <= 1'b0;
      o_Pending     <= 1'b0;
      o_FrameErr    <= 1'b0;
      o_Overrun     <= 1'b0;
    end else begin
      o_Start    <= 1'b0;
      o_FrameErr <= 1'b0;
      o_Overrun  <= 1'b0;

      // Idle counter only runs inside a frame while the line is between bytes;
      // every received byte (including the one entering GET_R) restarts it.
      if (!w_in_frame || r_byte_valid || w_abort) r_idle_cnt <= '0;
      else if (r_bit_state == B_IDLE)             r_idle_cnt <= r_idle_cnt + TW'(1);

      if (w_consume) begin
        o_Colour <= r_pend;
        o_Start  <= 1'b1;
      end

      // A completion in the same cycle as a consume replaces the value that
      // is being sent, so it is not an overrun and pending stays set.
      if (w_complete) begin
        r_pend    <= w_new_colour;
        o_Pending <= 1'b1;
        o_Overrun <= o_Pending && !w_consume;
      end else if (w_consume) begin
        o_Pending <= 1'b0;
      end

      if (w_abort) begin
        o_FrameErr    <= 1'b1;
        r_frame_state <= F_WAIT_SYNC;
        r_sh_r        <= '0;
        r_sh_g        <= '0;
`ifdef UART_COLOUR_CHECKSUM_EN
        r_sh_b        <= '0;
`endif
      end else if (r_byte_valid) begin
        case (r_frame_state)
          F_WAIT_SYNC: if (r_shift == SYNC_BYTE) r_frame_state <= F_GET_R;
          F_GET_R: begin
            r_sh_r        <= r_shift;
            r_frame_state <= F_GET_G;
          end
          F_GET_G: begin
            r_sh_g        <= r_shift;
            r_frame_state <= F_GET_B;
          end
`ifdef UART_COLOUR_CHECKSUM_EN
          F_GET_B: begin
            r_sh_b        <= r_shift;
            r_frame_state <= F_GET_CK;
          end
          F_GET_CK: r_frame_state <= F_WAIT_SYNC;
`else
          F_GET_B: r_frame_state <= F_WAIT_SYNC;
`endif
          default: r_frame_state <= F_WAIT_SYNC;
        endcase
      end
    end
  end

endmodule
